// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Purpose : Shared UART definitions for the transmitter and the planned
//           receiver: framing state encoding and a constant-width helper.
// Contents: uart_state_e (S_IDLE, S_START, S_DATA, S_PARITY, S_STOP),
//           clog2() for sizing counters from parameters.
// -----------------------------------------------------------------------------
package uart_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } uart_state_e;

   // Ceiling log2; returns 0 for values 0 and 1.
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned result;
      result = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(value)) result = i + 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// -----------------------------------------------------------------------------
// uart_sync_fifo
// Purpose : Single-clock FIFO with occupancy count, used as the UART transmit
//           queue. Reads are fall-through: rd_data_c shows the head entry.
// Ports   : clk, rst (synchronous, active-high)
//           push/wr_data  - write when push=1 and not full
//           pop           - discard head when pop=1 and not empty
//           rd_data_c     - head entry (combinational)
//           full_c/empty_c- occupancy flags (combinational from count)
//           count         - words held, 0..DEPTH (registered)
// -----------------------------------------------------------------------------
module uart_sync_fifo
   import uart_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        push,
   input  logic                        pop,
   input  logic [WIDTH-1:0]            wr_data,
   output logic [WIDTH-1:0]            rd_data_c,
   output logic                        full_c,
   output logic                        empty_c,
   output logic [clog2(DEPTH+1)-1:0]   count
);

   localparam int unsigned PTR_W = clog2(DEPTH);
   localparam int unsigned CNT_W = clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             push_ok_c, pop_ok_c;

   assign full_c    = (count_q == CNT_W'(DEPTH));
   assign empty_c   = (count_q == '0);
   assign rd_data_c = mem_q[rd_ptr_q];
   assign count     = count_q;

   // Pointer, count and storage update; pointers wrap since DEPTH is a power of 2.
   always_comb begin
      push_ok_c = push && !full_c;
      pop_ok_c  = pop && !empty_c;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      mem_d     = mem_q;
      if (push_ok_c) begin
         mem_d[wr_ptr_q] = wr_data;
         wr_ptr_d        = PTR_W'(wr_ptr_q + 1'b1);
      end
      if (pop_ok_c) rd_ptr_d = PTR_W'(rd_ptr_q + 1'b1);
      case ({push_ok_c, pop_ok_c})
         2'b10:   count_d = CNT_W'(count_q + 1'b1);
         2'b01:   count_d = CNT_W'(count_q - 1'b1);
         default: count_d = count_q;
      endcase
   end

   // Control registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is not reset; only entries between the pointers are ever read.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/uart_tx_fifo_param.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo_param
// Purpose : UART transmitter with a transmit FIFO. Frames are start bit,
//           DATA_BITS data bits LSB first, optional parity, STOP_BITS stop
//           bits; queued words go out back-to-back with one idle-high cycle.
// Config  : define UART_TX_PARITY_EN to add a parity bit (PARITY_ODD selects
//           odd parity); undefined builds carry no parity logic.
// Ports   : i_Clock, i_Reset (synchronous, active-high)
//           i_Tx_DV/i_Tx_Byte - push strobe and word, accepted when ready
//           o_Tx_Ready        - FIFO not full (combinational)
//           o_Tx_Overflow     - 1-cycle pulse when a push is dropped
//           o_Fifo_Count      - words waiting in the FIFO
//           o_Tx_Active       - high from start bit through last stop bit
//           o_Tx_Serial       - registered serial line, idles high
//           o_Tx_Done         - 1-cycle pulse after each frame completes
// -----------------------------------------------------------------------------
module uart_tx_fifo_param
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 139,
   parameter int unsigned DATA_BITS    = 8,
   parameter int unsigned STOP_BITS    = 1,
   parameter int unsigned FIFO_DEPTH   = 16,
   parameter int unsigned PARITY_ODD   = 0
) (
   input  logic                              i_Clock,
   input  logic                              i_Reset,
   input  logic                              i_Tx_DV,
   input  logic [DATA_BITS-1:0]              i_Tx_Byte,
   output logic                              o_Tx_Ready,
   output logic                              o_Tx_Overflow,
   output logic [clog2(FIFO_DEPTH+1)-1:0]    o_Fifo_Count,
   output logic                              o_Tx_Active,
   output logic                              o_Tx_Serial,
   output logic                              o_Tx_Done
);

   localparam int unsigned TIMER_W = clog2(CLKS_PER_BIT);
   localparam int unsigned IDX_W   = clog2(DATA_BITS);
   localparam int unsigned CNT_W   = clog2(FIFO_DEPTH + 1);

   if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535 || DATA_BITS < 5 || DATA_BITS > 9 ||
       STOP_BITS < 1 || STOP_BITS > 2 || FIFO_DEPTH < 2 ||
       (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || PARITY_ODD > 1) begin : g_bad_params
      $error("uart_tx_fifo_param: illegal parameter value");
   end

   uart_state_e          state_q, state_d;
   logic [TIMER_W-1:0]   timer_q, timer_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 serial_q, serial_d;
   logic                 active_q, active_d;
   logic                 done_q, done_d;
   logic                 ovf_q, ovf_d;
`ifdef UART_TX_PARITY_EN
   logic                 parity_q, parity_d;
`endif

   logic                 bit_end_c;
   logic                 fifo_pop_c;
   logic                 fifo_full_c;
   logic                 fifo_empty_c;
   logic [DATA_BITS-1:0] fifo_rd_data_c;
   logic [CNT_W-1:0]     fifo_count;

   uart_sync_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (i_Clock),
      .rst       (i_Reset),
      .push      (i_Tx_DV),
      .pop       (fifo_pop_c),
      .wr_data   (i_Tx_Byte),
      .rd_data_c (fifo_rd_data_c),
      .full_c    (fifo_full_c),
      .empty_c   (fifo_empty_c),
      .count     (fifo_count)
   );

   // Framing FSM. Line outputs are computed from the current state and
   // registered, so the line trails the state by one cycle; the done pulse
   // is taken from active_q so it lines up with the registered active fall.
   always_comb begin
      state_d    = state_q;
      timer_d    = '0;
      idx_d      = idx_q;
      shift_d    = shift_q;
      serial_d   = 1'b1;
      active_d   = 1'b1;
      done_d     = 1'b0;
      fifo_pop_c = 1'b0;
      ovf_d      = i_Tx_DV && fifo_full_c;
`ifdef UART_TX_PARITY_EN
      parity_d   = parity_q;
`endif
      bit_end_c  = (timer_q == TIMER_W'(CLKS_PER_BIT - 1));

      if (state_q != S_IDLE) timer_d = bit_end_c ? '0 : TIMER_W'(timer_q + 1'b1);

      case (state_q)
         S_IDLE: begin
            active_d = 1'b0;
            done_d   = active_q;
            idx_d    = '0;
            if (!fifo_empty_c) begin
               fifo_pop_c = 1'b1;
               shift_d    = fifo_rd_data_c;
`ifdef UART_TX_PARITY_EN
               parity_d   = (PARITY_ODD != 0) ? ~^fifo_rd_data_c : ^fifo_rd_data_c;
`endif
               state_d    = S_START;
            end
         end
         S_START: begin
            serial_d = 1'b0;
            if (bit_end_c) state_d = S_DATA;
         end
         S_DATA: begin
            serial_d = shift_q[0];
            if (bit_end_c) begin
               shift_d = shift_q >> 1;
               if (idx_q == IDX_W'(DATA_BITS - 1)) begin
                  idx_d = '0;
`ifdef UART_TX_PARITY_EN
                  state_d = S_PARITY;
`else
                  state_d = S_STOP;
`endif
               end else begin
                  idx_d = IDX_W'(idx_q + 1'b1);
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         S_PARITY: begin
            serial_d = parity_q;
            if (bit_end_c) state_d = S_STOP;
         end
`endif
         S_STOP: begin
            // idx_q counts stop bits here
            if (bit_end_c) begin
               if (idx_q == IDX_W'(STOP_BITS - 1)) begin
                  idx_d   = '0;
                  state_d = S_IDLE;
               end else begin
                  idx_d = IDX_W'(idx_q + 1'b1);
               end
            end
         end
         default: begin
            active_d = 1'b0;
            state_d  = S_IDLE;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         state_q  <= S_IDLE;
         timer_q  <= '0;
         idx_q    <= '0;
         shift_q  <= '0;
         serial_q <= 1'b1;
         active_q <= 1'b0;
         done_q   <= 1'b0;
         ovf_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         timer_q  <= timer_d;
         idx_q    <= idx_d;
         shift_q  <= shift_d;
         serial_q <= serial_d;
         active_q <= active_d;
         done_q   <= done_d;
         ovf_q    <= ovf_d;
`ifdef UART_TX_PARITY_EN
         parity_q <= parity_d;
`endif
      end
   end

   assign o_Tx_Ready    = !fifo_full_c;
   assign o_Tx_Overflow = ovf_q;
   assign o_Fifo_Count  = fifo_count;
   assign o_Tx_Active   = active_q;
   assign o_Tx_Serial   = serial_q;
   assign o_Tx_Done     = done_q;

endmodule
